c_sel_a_20bit: RTL and testbench

C_SEL_A_20BIT -- requirements
Module: c_sel_a_20bit

---
 rtl/c_sel_a_20bit_pkg.sv | 12 +
 rtl/csel_block.sv | 37 +++
 rtl/c_sel_a_20bit.sv | 73 +++++++
 tb/tb_c_sel_a_20bit.sv | 104 ++++++++++
 4 files changed

// File: rtl/c_sel_a_20bit_pkg.sv
// Shared constants and helpers for the carry-select adder.
package c_sel_a_20bit_pkg;

  localparam int unsigned DEF_WIDTH = 20;
  localparam int unsigned DEF_BLK   = 4;

  // Number of carry-select blocks, ceil(w / b).
  function automatic int unsigned num_blocks(input int unsigned w, input int unsigned b);
    return (w + b - 1) / b;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select stage: dual ripple adders (carry-in 0 and 1) and a select mux.
module csel_block #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_sel,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N-1:0] w_s0;
  logic [N-1:0] w_s1;
  logic         w_c0;
  logic         w_c1;

  always_comb begin
    logic k0;
    logic k1;
    k0   = 1'b0;
    k1   = 1'b1;
    w_s0 = '0;
    w_s1 = '0;
    for (int k = 0; k < N; k++) begin
      w_s0[k] = a[k] ^ b[k] ^ k0;
      w_s1[k] = a[k] ^ b[k] ^ k1;
      k0      = (a[k] & b[k]) | (k0 & (a[k] ^ b[k]));
      k1      = (a[k] & b[k]) | (k1 & (a[k] ^ b[k]));
    end
    w_c0 = k0;
    w_c1 = k1;
  end

  assign s     = c_sel ? w_s1 : w_s0;
  assign c_out = c_sel ? w_c1 : w_c0;

endmodule

// File: rtl/c_sel_a_20bit.sv
// Carry-select adder with combinational sum/carry and a registered copy.
module c_sel_a_20bit
  import c_sel_a_20bit_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH,
  parameter int unsigned BLK   = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             cin,
  output logic [width-1:0] S,
  output logic             cout,
  output logic [width-1:0] S_q,
  output logic             cout_q
);

  localparam int unsigned NB = num_blocks(width, BLK);

  logic [width-1:0] r_s;
  logic             r_cout;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int unsigned Lo = i * BLK;
    // The top block takes whatever bits remain.
    localparam int unsigned N  = (width - Lo < BLK) ? (width - Lo) : BLK;

    logic [N-1:0] w_s;
    logic         w_co;

    if (i == 0) begin : g_ripple
      always_comb begin
        logic c;
        c   = cin;
        w_s = '0;
        for (int k = 0; k < N; k++) begin
          w_s[k] = A[k] ^ B[k] ^ c;
          c      = (A[k] & B[k]) | (c & (A[k] ^ B[k]));
        end
        w_co = c;
      end
    end else begin : g_csel
      csel_block #(
        .N(N)
      ) u_blk (
        .a    (A[Lo+N-1:Lo]),
        .b    (B[Lo+N-1:Lo]),
        .c_sel(g_blk[i-1].w_co),
        .s    (w_s),
        .c_out(w_co)
      );
    end

    assign S[Lo+N-1:Lo] = w_s;
  end

  assign cout = g_blk[NB-1].w_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= S;
      r_cout <= cout;
    end
  end

  assign S_q    = r_s;
  assign cout_q = r_cout;

endmodule

// File: tb/tb_c_sel_a_20bit.sv
// Scoreboard bench: driver checks the combinational sum, monitor checks the registered copy.
module tb_c_sel_a_20bit;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] S;
  logic         cout;
  logic [W-1:0] S_q;
  logic         cout_q;

  int tests  = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  c_sel_a_20bit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout),
    .S_q   (S_q),
    .cout_q(cout_q)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Apply one vector for a full cycle; the registered result lands on the next posedge.
  task automatic drive(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic r);
    logic [W:0] m;
    @(negedge clk);
    A = a; B = b; cin = c; rst = r;
    m = model(a, b, c);
    #1;
    check({name, "_comb"}, {cout, S}, m);
    exp_q.push_back(r ? '0 : m);
  endtask

  // Monitor: each posedge the registers present a fresh result.
  initial begin
    logic [W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("reg", {cout_q, S_q}, e);
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    drive("rst_hold0", 20'hFFFFF, 20'hFFFFF, 1'b0, 1'b1);
    drive("rst_hold1", 20'hFFFFF, 20'hFFFFF, 1'b0, 1'b1);
    check("rst_comb_S", {1'b0, S}, {1'b0, 20'hFFFFE});
    drive("rst_release", 20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0);
    drive("v1", 20'h12345, 20'h6789A, 1'b0, 1'b0);
    drive("v2_full_ripple", 20'hFFFFF, 20'h00000, 1'b1, 1'b0);
    drive("v3_ones_ones", 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0);
    drive("v4_blk_boundary", 20'h0000F, 20'h00001, 1'b0, 1'b0);
    drive("v5_zero", 20'h00000, 20'h00000, 1'b0, 1'b0);
    drive("v6_alt", 20'hAAAAA, 20'h55555, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      drive("rand", ra, rb, rc, (i == 25) ? 1'b1 : 1'b0);
    end
    drive("post", 20'h7FFFF, 20'h00001, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
